// File: rtl/actuator_power_scheduler.sv
// actuator_power_scheduler
//   Gates the control core's per-actuator demand bits onto the actuator pins.
//   Each channel runs a small FSM that enforces minimum on and off times.
//   A round-robin arbiter grants at most one new load per cycle. It respects
//   the shared supply budget (MAX_ON) and the heater/cooler interlock.
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high (wins over en/pause)
//   en          clock enable; 0 freezes every register
//   pause       forces all channels off, blocks new grants
//   req         per-channel level demand
//   grant       registered actuator drive
//   active_cnt  registered popcount(grant)
//   full        registered, active_cnt == MAX_ON
module actuator_power_scheduler #(
  parameter int N_CH        = 5,
  parameter int MAX_ON      = 2,
  parameter int MIN_ON_CYC  = 25_000_000,
  parameter int MIN_OFF_CYC = 25_000_000,
  parameter int CNT_W       = 26,
  parameter int EXCL_A      = 1,
  parameter int EXCL_B      = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            pause,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] grant,
  output logic [2:0]      active_cnt,
  output logic            full
);

  localparam int             PTR_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] ON_RELOAD  = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_RELOAD = CNT_W'(MIN_OFF_CYC - 1);
  localparam logic [2:0]       MAX_ON_W   = 3'(MAX_ON);

  typedef enum logic [1:0] {
    OFF_READY = 2'd0,
    OFF_LOCK  = 2'd1,
    ON_LOCK   = 2'd2,
    ON_FREE   = 2'd3
  } ch_state_t;

  logic [N_CH-1:0]  grant_reg;
  logic [2:0]       active_cnt_reg;
  logic             full_reg;
  logic [PTR_W-1:0] rr_ptr_reg;
  logic [PTR_W-1:0] rr_ptr_next;

  logic [N_CH-1:0]  elig;        // channel may be granted this cycle
  logic [N_CH-1:0]  partner_on;  // interlock partner currently granted
  logic [N_CH-1:0]  cand;
  logic [N_CH-1:0]  win_onehot;
  logic [N_CH-1:0]  on_next;
  logic             win_valid;
  logic [PTR_W-1:0] win_idx;
  logic [2:0]       active_next;
  logic             budget_ok;

  // Budget and interlock use the registered grant vector. A channel that
  // releases this cycle therefore frees nothing until the following cycle.
  assign budget_ok = (active_cnt_reg < MAX_ON_W);
  assign cand      = req & elig & ~partner_on & {N_CH{budget_ok & ~pause}};

  // Round-robin search starting at rr_ptr; the first candidate found wins.
  always_comb begin
    int idx;
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(rr_ptr_reg) + k) % N_CH;
      if (!win_valid && cand[idx]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    if (win_valid) win_onehot[win_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (win_valid) begin
      rr_ptr_next = (int'(win_idx) == N_CH - 1) ? '0 : win_idx + PTR_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      ch_state_t        st_reg;
      ch_state_t        st_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      if (EXCL_A != EXCL_B && gi == EXCL_A) begin : g_pa
        assign partner_on[gi] = grant_reg[EXCL_B];
      end else if (EXCL_A != EXCL_B && gi == EXCL_B) begin : g_pb
        assign partner_on[gi] = grant_reg[EXCL_A];
      end else begin : g_pn
        assign partner_on[gi] = 1'b0;
      end

      // An expired OFF_LOCK counts as eligible, so it needs no dead cycle in OFF_READY.
      assign elig[gi]    = (st_reg == OFF_READY) ||
                           ((st_reg == OFF_LOCK) && (cnt_reg == '0));
      assign on_next[gi] = (st_next == ON_LOCK) || (st_next == ON_FREE);

      always_ff @(posedge clk) begin
        if (rst) begin
          st_reg  <= OFF_READY;
          cnt_reg <= '0;
        end else if (en) begin
          st_reg  <= st_next;
          cnt_reg <= cnt_next;
        end
      end

      // A win is impossible while pause is high, because cand is masked.
      always_comb begin
        st_next  = st_reg;
        cnt_next = cnt_reg;
        case (st_reg)
          OFF_READY: begin
            if (win_onehot[gi]) begin
              st_next  = ON_LOCK;
              cnt_next = ON_RELOAD;
            end
          end
          OFF_LOCK: begin
            if (cnt_reg != '0) begin
              cnt_next = cnt_reg - CNT_W'(1);
            end else if (win_onehot[gi]) begin
              st_next  = ON_LOCK;
              cnt_next = ON_RELOAD;
            end else begin
              st_next = OFF_READY;
            end
          end
          ON_LOCK: begin
            if (pause) begin
              st_next  = OFF_LOCK;
              cnt_next = OFF_RELOAD;
            end else if (cnt_reg != '0) begin
              cnt_next = cnt_reg - CNT_W'(1);
            end else if (!req[gi]) begin
              st_next  = OFF_LOCK;
              cnt_next = OFF_RELOAD;
            end else begin
              st_next = ON_FREE;
            end
          end
          ON_FREE: begin
            if (pause || !req[gi]) begin
              st_next  = OFF_LOCK;
              cnt_next = OFF_RELOAD;
            end
          end
          default: begin
            st_next  = OFF_READY;
            cnt_next = '0;
          end
        endcase
      end
    end
  endgenerate

  always_comb begin
    active_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      active_next = active_next + 3'(on_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_reg      <= '0;
      active_cnt_reg <= '0;
      full_reg       <= 1'b0;
      rr_ptr_reg     <= '0;
    end else if (en) begin
      grant_reg      <= on_next;
      active_cnt_reg <= active_next;
      full_reg       <= (active_next == MAX_ON_W);
      rr_ptr_reg     <= rr_ptr_next;
    end
  end

  assign grant      = grant_reg;
  assign active_cnt = active_cnt_reg;
  assign full       = full_reg;

endmodule
